// File: rtl/fifo_occupancy_ctrl_if.sv
// Request, pointer and status bundle between the FIFO pointer stages and the
// occupancy controller. The controller is the slave.
interface fifo_occupancy_ctrl_if #(
  parameter int PTR_W = 8,
  parameter int CNT_W = 4
);
  logic             wr_req;
  logic             rd_req;
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             err_clr;
  logic             full;
  logic             empty;
  logic             almost_full;
  logic             almost_empty;
  logic [CNT_W-1:0] count;
  logic             wr_accept;
  logic             rd_accept;
  logic             overflow_err;
  logic             underflow_err;
  logic             ptr_err;

  modport master (
    output wr_req, rd_req, wr_ptr, rd_ptr, err_clr,
    input  full, empty, almost_full, almost_empty, count,
           wr_accept, rd_accept, overflow_err, underflow_err, ptr_err
  );

  modport slave (
    input  wr_req, rd_req, wr_ptr, rd_ptr, err_clr,
    output full, empty, almost_full, almost_empty, count,
           wr_accept, rd_accept, overflow_err, underflow_err, ptr_err
  );
endinterface

// File: rtl/fifo_occupancy_ctrl.sv
// FIFO occupancy tracker: registered count, status flags derived from it,
// accept gating for the pointer stages and sticky overflow/underflow/pointer errors.
module fifo_occupancy_ctrl #(
  parameter int DEPTH     = 8,
  parameter int PTR_W     = 8,
  parameter int CNT_W     = 4,
  parameter int AF_THRESH = 6,
  parameter int AE_THRESH = 2
) (
  input  logic                  clk_in,
  input  logic                  sreset,
  fifo_occupancy_ctrl_if.slave  bus
);

  logic [CNT_W-1:0] count_q;
  logic             overflow_q;
  logic             underflow_q;
  logic             ptr_err_q;

  logic             full;
  logic             empty;
  logic             wr_accept;
  logic             rd_accept;
  logic [PTR_W-1:0] ptr_diff;
  logic             ptr_mismatch;

  // Flags decode only the count register, so requests never reach them combinationally.
  assign full  = (count_q == CNT_W'(DEPTH));
  assign empty = (count_q == '0);

  assign wr_accept = bus.wr_req & ~full;
  assign rd_accept = bus.rd_req & ~empty;

  // Modular subtraction absorbs pointer wrap at 2^PTR_W.
  assign ptr_diff     = bus.wr_ptr - bus.rd_ptr;
  assign ptr_mismatch = (ptr_diff != PTR_W'(count_q));

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk_in) begin
    if (sreset) begin
      count_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
      ptr_err_q   <= 1'b0;
    end else begin
      case ({wr_accept, rd_accept})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
      // NOTE: the set term is OR-ed after the clear so a new error wins over err_clr.
      overflow_q  <= (overflow_q  & ~bus.err_clr) | (bus.wr_req & full);
      underflow_q <= (underflow_q & ~bus.err_clr) | (bus.rd_req & empty);
      ptr_err_q   <= (ptr_err_q   & ~bus.err_clr) | ptr_mismatch;
    end
  end

  assign bus.full          = full;
  assign bus.empty         = empty;
  assign bus.almost_full   = (count_q >= CNT_W'(AF_THRESH));
  assign bus.almost_empty  = (count_q <= CNT_W'(AE_THRESH));
  assign bus.count         = count_q;
  assign bus.wr_accept     = wr_accept;
  assign bus.rd_accept     = rd_accept;
  assign bus.overflow_err  = overflow_q;
  assign bus.underflow_err = underflow_q;
  assign bus.ptr_err       = ptr_err_q;

endmodule

// File: tb/tb_fifo_occupancy_ctrl.sv
// Self-checking bench for fifo_occupancy_ctrl: directed boundary steps plus random
// traffic, compared against an occupancy/pointer model kept as plain integers.
module tb_fifo_occupancy_ctrl;
  localparam int DEPTH = 8;
  localparam int PTR_W = 8;
  localparam int CNT_W = 4;
  localparam int AF    = 6;
  localparam int AE    = 2;
  localparam int PMOD  = 1 << PTR_W;

  logic clk_in = 1'b0;
  logic sreset;

  fifo_occupancy_ctrl_if #(.PTR_W(PTR_W), .CNT_W(CNT_W)) bus ();

  fifo_occupancy_ctrl #(
    .DEPTH(DEPTH), .PTR_W(PTR_W), .CNT_W(CNT_W),
    .AF_THRESH(AF), .AE_THRESH(AE)
  ) dut (
    .clk_in (clk_in),
    .sreset (sreset),
    .bus    (bus)
  );

  always #5 clk_in = ~clk_in;

  int errors = 0;
  int checks = 0;

  // Reference model: occupancy, pointer positions and sticky error bits.
  int cnt = 0;
  int wp  = 0;
  int rp  = 0;
  bit ov  = 1'b0;
  bit un  = 1'b0;
  bit pe  = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_state(input string tag);
    check({tag, "/count"},        32'(bus.count),         32'(cnt));
    check({tag, "/full"},         32'(bus.full),          32'(cnt == DEPTH));
    check({tag, "/empty"},        32'(bus.empty),         32'(cnt == 0));
    check({tag, "/almost_full"},  32'(bus.almost_full),   32'(cnt >= AF));
    check({tag, "/almost_empty"}, 32'(bus.almost_empty),  32'(cnt <= AE));
    check({tag, "/overflow"},     32'(bus.overflow_err),  32'(ov));
    check({tag, "/underflow"},    32'(bus.underflow_err), 32'(un));
    check({tag, "/ptr_err"},      32'(bus.ptr_err),       32'(pe));
  endtask

  // One clock of traffic. bump adds a deliberate offset to the driven write pointer.
  task automatic step(input string tag, input bit w, input bit r, input bit clr, input bit bump);
    bit exp_wa;
    bit exp_ra;
    bit mism;
    int drv_wp;
    @(negedge clk_in);
    drv_wp      = (wp + (bump ? 1 : 0)) % PMOD;
    bus.wr_req  = w;
    bus.rd_req  = r;
    bus.err_clr = clr;
    bus.wr_ptr  = PTR_W'(drv_wp);
    bus.rd_ptr  = PTR_W'(rp);
    exp_wa = w && (cnt < DEPTH);
    exp_ra = r && (cnt > 0);
    #1;
    check({tag, "/wr_accept"}, 32'(bus.wr_accept), 32'(exp_wa));
    check({tag, "/rd_accept"}, 32'(bus.rd_accept), 32'(exp_ra));
    mism = (((drv_wp - rp) % PMOD + PMOD) % PMOD) != cnt;
    @(posedge clk_in);
    ov  = (w && cnt == DEPTH) || (ov && !clr);
    un  = (r && cnt == 0)     || (un && !clr);
    pe  = mism                || (pe && !clr);
    cnt = cnt + int'(exp_wa) - int'(exp_ra);
    wp  = (wp + int'(exp_wa)) % PMOD;
    rp  = (rp + int'(exp_ra)) % PMOD;
    #1;
    check_state(tag);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    sreset      = 1'b1;
    bus.wr_req  = 1'b1;
    bus.rd_req  = 1'b1;
    bus.err_clr = 1'b0;
    bus.wr_ptr  = '0;
    bus.rd_ptr  = '0;
    repeat (2) @(posedge clk_in);
    @(negedge clk_in);
    sreset = 1'b0;
    bus.wr_req = 1'b0;
    bus.rd_req = 1'b0;
    check_state("reset");

    repeat (3) step("idle", 0, 0, 0, 0);

    // Fill past full: 9th write is rejected and flags overflow.
    for (int i = 0; i < 9; i++) step("fill", 1, 0, 0, 0);
    check("fill/wr_ptr_held", 32'(wp), 32'd8);

    step("both_at_full", 1, 1, 0, 0);
    step("clear1", 0, 0, 1, 0);

    while (cnt > 0) step("drain", 0, 1, 0, 0);
    step("both_at_empty", 1, 1, 0, 0);

    step("clear2", 1, 0, 1, 0);
    step("write", 1, 0, 0, 0);
    for (int i = 0; i < 20; i++) step("steady", 1, 1, 0, 0);

    // Long balanced stream so both pointers wrap past 2^PTR_W.
    for (int i = 0; i < 300; i++) step("wrap", 1, 1, 0, 0);
    check("wrap/ptr_wrapped", 32'(wp < 300 - 20), 32'd1);

    for (int i = 0; i < 200; i++)
      step("random", 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 15) == 0), 0);

    step("clear3", 0, 0, 1, 0);
    step("mismatch", 0, 0, 0, 1);
    repeat (3) step("ptr_hold", 0, 0, 0, 0);
    step("clear4", 0, 0, 1, 0);

    while (cnt > 0) step("drain2", 0, 1, 0, 0);
    step("clr_vs_set", 0, 1, 1, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
